spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
// SPI responder: the peripheral-side counterpart of spi_master. It oversamples an external SCLK/CS_N/MOSI with the system clock.
// Deserialises MOSI into bytes and serialises a one-byte transmit buffer onto MISO, MSB first, all four SPI modes.
// Sits between the board SPI pins and user logic; user side is a byte-wide valid/ready pair per direction.
// PARAMETERS
// SPI_MODE  0        0..3; CPOL = (SPI_MODE==2|3), CPHA = (SPI_MODE==1|3)
// IDLE_BYTE 8'hFF    byte shifted out on MISO when no user byte is buffered
// PORTS
// clk            in   1  system clock; all logic on posedge; must be >= 8x SCLK
// rst            in   1  asynchronous, active-high reset
// i_spi_clk      in   1  SCLK from master (asynchronous to clk)
// i_spi_cs_n     in   1  chip select, active low (asynchronous)
// i_spi_mosi     in   1  serial data from master
// o_spi_miso     out  1  serial data to master
// o_spi_miso_oe  out  1  MISO output enable (1 while CS_N low)
// o_mosi_byte    out  8  last complete byte received on MOSI
// o_mosi_dv      out  1  1-clk pulse: o_mosi_byte updated
// i_miso_byte    in   8  next byte to send on MISO
// i_miso_dv      in   1  write strobe for i_miso_byte; accepted only when o_miso_ready=1
// o_miso_ready   out  1  transmit holding register empty
// BEHAVIOUR
// - Reset (async, rst=1): o_mosi_byte=0, o_mosi_dv=0, o_miso_ready=1, o_spi_miso=1, o_spi_miso_oe=0; FSM->IDLE; holding empty; sync flops to idle (SCLK=CPOL, CS_N=1).
// - Sync: SCLK, CS_N, MOSI each pass 2 flops; one extra SCLK/CS_N stage for edge detect. Pin edge -> internal event 3 clk later.
// - Leading edge = SCLK leaving CPOL level; trailing = returning. Sample edge: leading if CPHA=0, else trailing. Shift edge: the other one.
// - FSM IDLE: wait for synced CS_N fall -> LOAD. LOAD (1 clk): shift reg <= holding (holding emptied, ready=1) or IDLE_BYTE; bitcnt=0; oe=1 -> ACTIVE.
// - CPHA=0: MISO=shreg[7] from LOAD; each shift edge presents next bit; shift edge after 8th sample re-enters LOAD for next byte.
// - CPHA=1: first leading edge in byte drives shreg[7]; later leading edges present next bit; LOAD occurs after 8th sample (trailing) edge.
// - ACTIVE: each sample edge shifts synced MOSI into rx shreg LSB, bitcnt++. On 8th sample: o_mosi_byte<=rx shreg, o_mosi_dv=1 for exactly 1 clk (<=4 clk after pin edge).
// - Consecutive bytes within one CS_N low: unlimited, no gap required; bitcnt wraps 7->0.
// - Holding register: i_miso_dv & o_miso_ready -> store, ready=0 next clk. i_miso_dv & !ready -> ignored. LOAD uses holding content at start of that clk; same-cycle write lands in holding for next byte.
// - CS_N rise (synced) in any state -> IDLE next clk: oe=0, o_spi_miso=1, partial rx bits discarded (no dv), bitcnt=0. Byte already in tx shreg is consumed/lost; holding untouched.
// - CS_N rise coincident with 8th sample edge: sample completes, dv still pulses, then IDLE.
// - SCLK edges while CS_N high: ignored. CS_N glitch < 3 clk: may be filtered; no requirement.
// TESTING
// 1 Mode 0, master sends 8'hA5, holding=8'h3C: o_mosi_dv pulses once, o_mosi_byte=8'hA5; MISO bits sampled on rising = 8'h3C.
// 2 Modes 1,2,3, same exchange 8'h5A/8'hC3: correct bytes both directions, MISO stable at every master sample edge.
// 3 Three back-to-back bytes 01,02,03 under one CS_N low, holding refilled only before byte 1: three dv pulses; MISO returns load byte, then FF, FF.
// 4 CS_N raised after 5 bits, then new 8'h81 frame: no dv for partial; next dv gives 8'h81; bitcnt restarted.
// 5 i_miso_dv twice with ready=0 (8'h11 then 8'h22): second ignored; MISO sends 8'h11; ready returns 1 at LOAD.
// 6 rst asserted mid-byte (bit 4): all outputs at reset values immediately, no dv; after release a full frame 8'hF0 is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_N/MOSI with clk, receives MOSI bytes and
// serialises a one-byte holding register (or IDLE_BYTE) onto MISO, MSB first.
module spi_slave #(
  parameter int unsigned SPI_MODE  = 0,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  output logic [7:0] o_mosi_byte,
  output logic       o_mosi_dv,
  input  logic [7:0] i_miso_byte,
  input  logic       i_miso_dv,
  output logic       o_miso_ready
);

  localparam logic CPOL = (SPI_MODE >= 2);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [2:0]  cs_q, cs_d;
  logic [1:0]  mosi_q, mosi_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        done_q, done_d;
  logic        first_q, first_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  mosi_byte_q, mosi_byte_d;
  logic        mosi_dv_q, mosi_dv_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;

  logic        sclk_edge, lead_ev, trail_ev, sample_ev, shift_ev;
  logic        cs_fall, cs_high;
  logic [7:0]  load_byte;

  always_comb begin
    sclk_d      = {sclk_q[1:0], i_spi_clk};
    cs_d        = {cs_q[1:0], i_spi_cs_n};
    mosi_d      = {mosi_q[0], i_spi_mosi};
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bitcnt_d    = bitcnt_q;
    done_d      = done_q;
    first_d     = first_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    mosi_byte_d = mosi_byte_q;
    mosi_dv_d   = 1'b0;
    miso_d      = miso_q;
    oe_d        = oe_q;

    sclk_edge = sclk_q[1] ^ sclk_q[2];
    lead_ev   = sclk_edge && (sclk_q[1] != CPOL);
    trail_ev  = sclk_edge && (sclk_q[1] == CPOL);
    sample_ev = CPHA ? trail_ev : lead_ev;
    shift_ev  = CPHA ? lead_ev : trail_ev;
    cs_fall   = cs_q[2] && !cs_q[1];
    cs_high   = cs_q[1];
    load_byte = hold_full_q ? hold_q : IDLE_BYTE;

    case (state_q)
      S_IDLE: begin
        miso_d   = 1'b1;
        oe_d     = 1'b0;
        bitcnt_d = '0;
        done_d   = 1'b0;
        first_d  = 1'b0;
        if (cs_fall) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (cs_high) begin
          state_d = S_IDLE;
          miso_d  = 1'b1;
          oe_d    = 1'b0;
        end else begin
          tx_d        = load_byte;
          hold_full_d = 1'b0;
          bitcnt_d    = '0;
          done_d      = 1'b0;
          first_d     = 1'b1;
          oe_d        = 1'b1;
          if (!CPHA) miso_d = load_byte[7];
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (sample_ev) begin
          rx_d     = {rx_q[6:0], mosi_q[1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            mosi_byte_d = rx_d;
            mosi_dv_d   = 1'b1;
            done_d      = 1'b1;
            if (CPHA) state_d = S_LOAD;
          end
        end
        if (shift_ev) begin
          // CPHA=0 reloads on the shift edge after the 8th sample instead of shifting
          if (!CPHA && done_q) begin
            state_d = S_LOAD;
          end else if (CPHA && first_q) begin
            miso_d  = tx_q[7];
            first_d = 1'b0;
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            miso_d = tx_q[6];
          end
        end
        // CS_N release overrides any reload but lets a completing byte still report
        if (cs_high) begin
          state_d  = S_IDLE;
          oe_d     = 1'b0;
          miso_d   = 1'b1;
          bitcnt_d = '0;
          done_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Write check uses the start-of-cycle ready, so a write during LOAD of an empty
    // holding register lands for the following byte.
    if (i_miso_dv && !hold_full_q) begin
      hold_d      = i_miso_byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sclk_q      <= {3{CPOL}};
      cs_q        <= '1;
      mosi_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      bitcnt_q    <= '0;
      done_q      <= 1'b0;
      first_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      mosi_byte_q <= '0;
      mosi_dv_q   <= 1'b0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bitcnt_q    <= bitcnt_d;
      done_q      <= done_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      mosi_byte_q <= mosi_byte_d;
      mosi_dv_q   <= mosi_dv_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
    end
  end

  assign o_spi_miso    = miso_q;
  assign o_spi_miso_oe = oe_q;
  assign o_mosi_byte   = mosi_byte_q;
  assign o_mosi_dv     = mosi_dv_q;
  assign o_miso_ready  = !hold_full_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, driven by a behavioural SPI
// master and checked against a byte-level holding-register model.
module tb_spi_slave;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk, cs_n, mosi, miso, oe, mosi_dv, miso_dv, ready;
  logic [7:0] mosi_byte [4];
  logic [7:0] miso_byte [4];

  int checks = 0;
  int errors = 0;

  bit         hold_v  [4];
  logic [7:0] hold_b  [4];
  int         dv_cnt  [4] = '{default: 0};
  logic [7:0] last_rx [4];
  logic [7:0] fd      [3];

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave #(.SPI_MODE(g), .IDLE_BYTE(8'hFF)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_spi_clk    (sclk[g]),
        .i_spi_cs_n   (cs_n[g]),
        .i_spi_mosi   (mosi[g]),
        .o_spi_miso   (miso[g]),
        .o_spi_miso_oe(oe[g]),
        .o_mosi_byte  (mosi_byte[g]),
        .o_mosi_dv    (mosi_dv[g]),
        .i_miso_byte  (miso_byte[g]),
        .i_miso_dv    (miso_dv[g]),
        .o_miso_ready (ready[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (mosi_dv[m] === 1'b1) begin
        dv_cnt[m]++;
        last_rx[m] = mosi_byte[m];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic cpol_of(input int m);
    return (m >= 2);
  endfunction

  function automatic int cpha_of(input int m);
    return m % 2;
  endfunction

  task automatic consume(input int m, output logic [7:0] b);
    if (hold_v[m]) begin
      b = hold_b[m];
      hold_v[m] = 1'b0;
    end else begin
      b = 8'hFF;
    end
  endtask

  task automatic write_hold(input int m, input logic [7:0] b);
    miso_byte[m] = b;
    miso_dv[m]   = 1'b1;
    wait_clk(1);
    miso_dv[m]   = 1'b0;
    if (!hold_v[m]) begin
      hold_v[m] = 1'b1;
      hold_b[m] = b;
    end
    wait_clk(1);
    check($sformatf("ready_after_write_m%0d", m), 32'(ready[m]), 32'(!hold_v[m]));
  endtask

  task automatic shift_bits(input int m, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output bit stable);
    logic pre, s;
    rx = '0;
    stable = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      mosi[m] = tx[7-i];
      for (int e = 0; e < 2; e++) begin
        wait_clk(H - 2);
        pre = miso[m];
        wait_clk(2);
        s = miso[m];
        sclk[m] = (e == 0) ? ~cpol_of(m) : cpol_of(m);
        if (e == cpha_of(m)) begin
          rx[7-i] = s;
          if (pre !== s) stable = 1'b0;
          wait_clk(3);
          if (miso[m] !== s) stable = 1'b0;
        end
      end
    end
    wait_clk(H);
  endtask

  task automatic run_frame(input int m, input int n, input int wr_after, input logic [7:0] wr_val);
    logic [7:0] exp_tx, rx;
    bit st;
    int prev;
    cs_n[m] = 1'b0;
    consume(m, exp_tx);
    wait_clk(H);
    check($sformatf("oe_active_m%0d", m), 32'(oe[m]), 32'd1);
    check($sformatf("ready_at_load_m%0d", m), 32'(ready[m]), 32'(!hold_v[m]));
    for (int b = 0; b < n; b++) begin
      prev = dv_cnt[m];
      shift_bits(m, fd[b], 8, rx, st);
      check($sformatf("dv_pulses_m%0d_b%0d", m, b), 32'(dv_cnt[m] - prev), 32'd1);
      check($sformatf("mosi_byte_m%0d_b%0d", m, b), 32'(last_rx[m]), 32'(fd[b]));
      check($sformatf("miso_byte_m%0d_b%0d", m, b), 32'(rx), 32'(exp_tx));
      check($sformatf("miso_stable_m%0d_b%0d", m, b), 32'(st), 32'd1);
      consume(m, exp_tx);
      if (b == wr_after) write_hold(m, wr_val);
    end
    cs_n[m] = 1'b1;
    wait_clk(2 * H);
    check($sformatf("oe_idle_m%0d", m), 32'(oe[m]), 32'd0);
    check($sformatf("miso_idle_m%0d", m), 32'(miso[m]), 32'd1);
  endtask

  initial begin
    logic [7:0] rx, tmp;
    bit st;
    int prev, n;

    rst       = 1'b1;
    sclk      = 4'b1100;
    cs_n      = '1;
    mosi      = '0;
    miso_dv   = '0;
    for (int m = 0; m < 4; m++) begin
      miso_byte[m] = '0;
      hold_v[m]    = 1'b0;
      hold_b[m]    = '0;
      last_rx[m]   = '0;
    end
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("rst_miso_m%0d", m), 32'(miso[m]), 32'd1);
      check($sformatf("rst_oe_m%0d", m), 32'(oe[m]), 32'd0);
      check($sformatf("rst_ready_m%0d", m), 32'(ready[m]), 32'd1);
      check($sformatf("rst_dv_m%0d", m), 32'(mosi_dv[m]), 32'd0);
      check($sformatf("rst_byte_m%0d", m), 32'(mosi_byte[m]), 32'd0);
    end
    rst = 1'b0;
    wait_clk(3);

    // mode 0 basic exchange
    write_hold(0, 8'h3C);
    fd[0] = 8'hA5; fd[1] = 8'h00; fd[2] = 8'h00;
    run_frame(0, 1, -1, 8'h00);

    // modes 1..3 basic exchange
    for (int m = 1; m < 4; m++) begin
      write_hold(m, 8'hC3);
      fd[0] = 8'h5A;
      run_frame(m, 1, -1, 8'h00);
    end

    // back-to-back bytes, holding filled only before the first
    for (int m = 0; m < 4; m++) begin
      write_hold(m, 8'h96);
      fd[0] = 8'h01; fd[1] = 8'h02; fd[2] = 8'h03;
      run_frame(m, 3, -1, 8'h00);
    end

    // aborted partial byte, then a fresh frame
    for (int m = 0; m < 4; m++) begin
      cs_n[m] = 1'b0;
      consume(m, tmp);
      wait_clk(H);
      prev = dv_cnt[m];
      shift_bits(m, 8'hB5, 5, rx, st);
      cs_n[m] = 1'b1;
      wait_clk(2 * H);
      check($sformatf("partial_no_dv_m%0d", m), 32'(dv_cnt[m] - prev), 32'd0);
      check($sformatf("partial_oe_m%0d", m), 32'(oe[m]), 32'd0);
      fd[0] = 8'h81;
      run_frame(m, 1, -1, 8'h00);
    end

    // second write while full is ignored
    for (int m = 0; m < 4; m++) begin
      write_hold(m, 8'h11);
      write_hold(m, 8'h22);
      fd[0] = 8'($urandom);
      run_frame(m, 1, -1, 8'h00);
    end

    // randomized frames
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 1) == 1) write_hold(m, 8'($urandom));
        if ($urandom_range(0, 3) == 0) write_hold(m, 8'($urandom));
        n = $urandom_range(1, 3);
        for (int b = 0; b < 3; b++) fd[b] = 8'($urandom);
        run_frame(m, n, $urandom_range(0, 3) - 1, 8'($urandom));
      end
    end

    // reset in the middle of bit 4
    for (int r = 0; r < 2; r++) begin
      int m;
      m = (r == 0) ? 0 : 3;
      write_hold(m, 8'h5E);
      cs_n[m] = 1'b0;
      consume(m, tmp);
      wait_clk(H);
      prev = dv_cnt[m];
      shift_bits(m, 8'hA0, 4, rx, st);
      mosi[m] = 1'b0;
      wait_clk(H);
      sclk[m] = ~cpol_of(m);
      wait_clk(2);
      rst = 1'b1;
      #1;
      check($sformatf("midrst_miso_m%0d", m), 32'(miso[m]), 32'd1);
      check($sformatf("midrst_oe_m%0d", m), 32'(oe[m]), 32'd0);
      check($sformatf("midrst_ready_m%0d", m), 32'(ready[m]), 32'd1);
      check($sformatf("midrst_dv_m%0d", m), 32'(mosi_dv[m]), 32'd0);
      check($sformatf("midrst_byte_m%0d", m), 32'(mosi_byte[m]), 32'd0);
      for (int j = 0; j < 4; j++) hold_v[j] = 1'b0;
      @(negedge clk);
      sclk[m] = cpol_of(m);
      cs_n[m] = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(4);
      check($sformatf("midrst_no_dv_m%0d", m), 32'(dv_cnt[m] - prev), 32'd0);
      fd[0] = 8'hF0;
      run_frame(m, 1, -1, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
